scaler_vout_wall: RTL and testbench

//  Write side of the scaler output ping-pong line buffer, directly upstream of the line reader.

---
 rtl/scaler_vout_wall.sv | 183 ++++++++++++++++++
 tb/tb_scaler_vout_wall.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_vout_wall.sv
// Write side of the scaler output ping-pong line buffer.
// Scaled pixels arrive on a valid/ready stream. Each line of des_h beats is
// written into the PING or PONG BRAM. The block tells the reader when a full
// line is waiting, and frees a buffer when the reader pulses rdone.
//
// Handshake: a beat transfers on any rising edge where s_axis_valid and
// s_axis_ready are both 1. s_axis_ready is decoded from registers only and
// never looks at s_axis_valid. The producer must hold pixel/eol steady while
// valid is 1 and ready is 0.
module scaler_vout_wall #(
    parameter int PIXEL_NUM          = 1,
    parameter int IMG_H_MAX          = 1920,
    parameter int IMG_V_MAX          = 1080,
    parameter int IMG_H_BITWIDTH     = $clog2(IMG_H_MAX),
    parameter int IMG_V_BITWIDTH     = $clog2(IMG_V_MAX),
    parameter int BRAM_ADDR_BITWIDTH = 11,
    parameter int BRAM_DATA_BITWIDTH = 8
) (
    input  logic                                      core_clk,
    input  logic                                      core_rst,
    input  logic                                      core_start,
    input  logic [IMG_H_BITWIDTH-1:0]                 core_arg_img_des_h,
    input  logic [IMG_V_BITWIDTH-1:0]                 core_arg_img_des_v,
    input  logic                                      s_axis_valid,
    output logic                                      s_axis_ready,
    input  logic [BRAM_DATA_BITWIDTH*PIXEL_NUM-1:0]   s_axis_pixel,
    input  logic                                      s_axis_eol,
    output logic [2*PIXEL_NUM-1:0]                    ena,
    output logic [BRAM_ADDR_BITWIDTH-1:0]             addra,
    output logic [2*BRAM_DATA_BITWIDTH*PIXEL_NUM-1:0] dina,
    input  logic                                      rdone,
    output logic [PIXEL_NUM-1:0]                      rempty,
    output logic                                      wr_done,
    output logic                                      eol_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LINE   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic PING = 1'b0;
    localparam logic PONG = 1'b1;

    logic [1:0]                state;
    logic [1:0]                full;
    logic                      wsel;
    logic                      rsel;
    logic [IMG_H_BITWIDTH-1:0] h_cnt;
    logic [IMG_V_BITWIDTH-1:0] v_cnt;
    logic [IMG_H_BITWIDTH-1:0] des_h;
    logic [IMG_V_BITWIDTH-1:0] des_v;

    logic                      accept;
    logic                      last_beat;
    logic                      last_line;
    logic                      rdone_ok;
    logic                      commit;
    logic                      args_zero;
    logic [1:0]                full_n;
    logic                      rsel_n;

    // Ready only while filling a line whose target buffer is free
    assign s_axis_ready = (state == ST_LINE) && !full[wsel];
    assign accept       = s_axis_valid && s_axis_ready;
    assign last_beat    = (h_cnt == des_h - IMG_H_BITWIDTH'(1));
    assign last_line    = (v_cnt == des_v - IMG_V_BITWIDTH'(1));
    assign commit       = (state == ST_COMMIT);
    // An rdone aimed at an empty buffer is a stray pulse and is dropped
    assign rdone_ok     = rdone && full[rsel];
    assign args_zero    = (core_arg_img_des_h == '0) || (core_arg_img_des_v == '0);

    // Next occupancy: commit fills the write buffer, rdone frees the read buffer
    always_comb begin
        full_n = full;
        rsel_n = rsel;
        if (commit) begin
            full_n[wsel] = 1'b1;
        end
        if (rdone_ok) begin
            full_n[rsel] = 1'b0;
            rsel_n       = ~rsel;
        end
    end

    // Occupancy, buffer selectors and the registered line-available flag
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            full   <= 2'b00;
            wsel   <= PING;
            rsel   <= PING;
            rempty <= '0;
        end else begin
            full   <= full_n;
            rsel   <= rsel_n;
            rempty <= {PIXEL_NUM{full_n[rsel_n]}};
            if (commit) begin
                wsel <= ~wsel;
            end
        end
    end

    // Frame sequencing: argument latch, beat/line counters, wr_done pulse
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state   <= ST_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            des_h   <= '0;
            des_v   <= '0;
            wr_done <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_start) begin
                        des_h <= core_arg_img_des_h;
                        des_v <= core_arg_img_des_v;
                        h_cnt <= '0;
                        v_cnt <= '0;
                        if (args_zero) begin
                            // Empty frame: nothing to write, report completion at once
                            state   <= ST_DONE;
                            wr_done <= 1'b1;
                        end else begin
                            state <= ST_LINE;
                        end
                    end
                end
                ST_LINE: begin
                    if (accept) begin
                        if (last_beat) begin
                            h_cnt <= '0;
                            state <= ST_COMMIT;
                            if (last_line) begin
                                wr_done <= 1'b1;
                            end
                        end else begin
                            h_cnt <= h_cnt + IMG_H_BITWIDTH'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    v_cnt <= v_cnt + IMG_V_BITWIDTH'(1);
                    state <= last_line ? ST_DONE : ST_LINE;
                end
                default: begin
                    // Stay here until the reader has drained both buffers
                    if (full == 2'b00) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // BRAM write port, one cycle behind the accepted beat; eol cross-check
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            ena     <= '0;
            addra   <= '0;
            dina    <= '0;
            eol_err <= 1'b0;
        end else begin
            ena <= '0;
            if (accept) begin
                addra <= BRAM_ADDR_BITWIDTH'(h_cnt);
                for (int j = 0; j < PIXEL_NUM; j++) begin
                    ena[2*j +: 2] <= (wsel == PING) ? 2'b01 : 2'b10;
                    dina[(2*j)*BRAM_DATA_BITWIDTH +: BRAM_DATA_BITWIDTH] <=
                        s_axis_pixel[j*BRAM_DATA_BITWIDTH +: BRAM_DATA_BITWIDTH];
                    dina[(2*j+1)*BRAM_DATA_BITWIDTH +: BRAM_DATA_BITWIDTH] <=
                        s_axis_pixel[j*BRAM_DATA_BITWIDTH +: BRAM_DATA_BITWIDTH];
                end
                // Framing always follows h_cnt; a disagreeing eol is only flagged
                if (s_axis_eol != last_beat) begin
                    eol_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scaler_vout_wall.sv
// Directed bench for scaler_vout_wall: ping-pong fill, back-pressure,
// simultaneous commit/rdone, eol checking, empty frames and async reset.
module tb_scaler_vout_wall;

    localparam int W = 29; // {ena[1:0], addra[10:0], dina[15:0]}

    logic        clk;
    logic        rst;
    logic        start;
    logic [10:0] des_h;
    logic [10:0] des_v;
    logic        valid;
    logic        ready;
    logic [7:0]  pixel;
    logic        eol;
    logic [1:0]  ena;
    logic [10:0] addra;
    logic [15:0] dina;
    logic        rdone;
    logic [0:0]  rempty;
    logic        wr_done;
    logic        eol_err;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           total;
    int           bad;
    int           wr_cnt;

    scaler_vout_wall dut (
        .core_clk           (clk),
        .core_rst           (rst),
        .core_start         (start),
        .core_arg_img_des_h (des_h),
        .core_arg_img_des_v (des_v),
        .s_axis_valid       (valid),
        .s_axis_ready       (ready),
        .s_axis_pixel       (pixel),
        .s_axis_eol         (eol),
        .ena                (ena),
        .addra              (addra),
        .dina               (dina),
        .rdone              (rdone),
        .rempty             (rempty),
        .wr_done            (wr_done),
        .eol_err            (eol_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port and wr_done monitor, sampled mid-cycle
    always begin
        @(negedge clk);
        if (ena != 2'b00) got_q.push_back({ena, addra, dina});
        if (wr_done) wr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [7:0] pix, input logic e, input logic [1:0] en, input int addr);
        int n;
        valid = 1'b1;
        pixel = pix;
        eol   = e;
        n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        check("ready_wait", n < 100, 1);
        exp_q.push_back({en, 11'(addr), pix, pix});
        step();
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input logic [1:0] en, input int eol_idx);
        for (int i = 0; i < n; i++) begin
            send_beat(base + 8'(i), (i == eol_idx), en, i);
        end
    endtask

    task automatic pulse_rdone();
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        step();
    endtask

    task automatic start_frame(input int h, input int v);
        des_h = 11'(h);
        des_v = 11'(v);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0;
        rst = 1'b1; start = 1'b0; des_h = '0; des_v = '0;
        valid = 1'b0; pixel = '0; eol = 1'b0; rdone = 1'b0;
        step(); step();
        check("rst_ena", ena, 2'b00);
        check("rst_addra", addra, 11'd0);
        check("rst_dina", dina, 16'd0);
        check("rst_rempty", rempty, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        check("rst_eol_err", eol_err, 1'b0);
        check("rst_ready", ready, 1'b0);
        rst = 1'b0;
        step();

        // A: 4x2 frame, valid held high, PING then PONG
        start_frame(4, 2);
        send_line(4, 8'h10, 2'b01, 3);
        send_line(4, 8'h20, 2'b10, 3);
        valid = 1'b0;
        step();
        check("a_ready_done", ready, 1'b0);
        step(); step(); step();
        check("a_wr_cnt", wr_cnt, 1);
        check("a_rempty_full", rempty, 1'b1);
        check("a_eol_err", eol_err, 1'b0);
        pulse_rdone();
        check("a_rempty_pong", rempty, 1'b1);
        step(); step(); step();
        pulse_rdone();
        check("a_rempty_drained", rempty, 1'b0);
        step();
        check_writes("a_wr");

        // B: 4x3 frame, no reader -> stall after two lines
        start_frame(4, 3);
        send_line(4, 8'h30, 2'b01, 3);
        send_line(4, 8'h40, 2'b10, 3);
        valid = 1'b1; pixel = 8'h50; eol = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("b_stall_ready", ready, 1'b0);
        check("b_rempty", rempty, 1'b1);
        check_writes("b_stall_wr");
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        check("b_ready_after_rdone", ready, 1'b1);
        send_line(4, 8'h50, 2'b01, 3);
        valid = 1'b0;
        step(); step(); step();
        check("b_wr_cnt", wr_cnt, 2);
        check("b_rempty_full", rempty, 1'b1);
        pulse_rdone();
        check("b_rempty_one", rempty, 1'b1);
        pulse_rdone();
        check("b_rempty_drained", rempty, 1'b0);
        step();
        check_writes("b_wr");

        // C: commit of last line coincides with rdone
        start_frame(2, 2);
        send_line(2, 8'h60, 2'b10, 1);
        send_line(2, 8'h70, 2'b01, 1);
        valid = 1'b0;
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        check("c_rempty_swap", rempty, 1'b1);
        step();
        pulse_rdone();
        check("c_rempty_drained", rempty, 1'b0);
        pulse_rdone();
        check("c_rempty_stray", rempty, 1'b0);
        check("c_wr_cnt", wr_cnt, 3);
        check_writes("c_wr");

        // D: early eol on beat 2 of a 4-beat line
        start_frame(4, 1);
        send_line(4, 8'h80, 2'b10, 2);
        valid = 1'b0; eol = 1'b0;
        step(); step();
        check("d_eol_err", eol_err, 1'b1);
        check("d_wr_cnt", wr_cnt, 4);
        check("d_rempty", rempty, 1'b1);
        pulse_rdone();
        check("d_rempty_drained", rempty, 1'b0);
        check_writes("d_wr");

        // E: zero-width frame
        start_frame(0, 5);
        check("e_wr_done_pulse", wr_done, 1'b1);
        step();
        check("e_wr_done_low", wr_done, 1'b0);
        check("e_ready", ready, 1'b0);
        step(); step();
        check("e_wr_cnt", wr_cnt, 5);
        check_writes("e_wr");

        // F: core_start during a line is ignored; eol_err stays set
        start_frame(2, 1);
        start_frame(7, 9);
        send_line(2, 8'h90, 2'b01, 1);
        valid = 1'b0;
        step(); step();
        check("f_wr_cnt", wr_cnt, 6);
        check("f_ready", ready, 1'b0);
        check("f_eol_sticky", eol_err, 1'b1);
        check("f_rempty", rempty, 1'b1);
        pulse_rdone();
        check("f_rempty_drained", rempty, 1'b0);
        check_writes("f_wr");

        // G: reset in the middle of line 2
        start_frame(4, 3);
        send_line(4, 8'hA0, 2'b10, 3);
        send_beat(8'hB0, 1'b0, 2'b01, 0);
        send_beat(8'hB1, 1'b0, 2'b01, 1);
        check("g_ena_before_rst", ena, 2'b01);
        check("g_rempty_before_rst", rempty, 1'b1);
        #2;
        rst = 1'b1;
        valid = 1'b0;
        #1;
        check("g_rst_ena", ena, 2'b00);
        check("g_rst_addra", addra, 11'd0);
        check("g_rst_dina", dina, 16'd0);
        check("g_rst_rempty", rempty, 1'b0);
        check("g_rst_eol_err", eol_err, 1'b0);
        check("g_rst_ready", ready, 1'b0);
        check("g_rst_wr_done", wr_done, 1'b0);
        void'(exp_q.pop_back());
        step(); step();
        check_writes("g_pre_rst_wr");
        rst = 1'b0;
        step();
        start_frame(2, 1);
        send_line(2, 8'hC0, 2'b01, 1);
        valid = 1'b0;
        step(); step();
        check("g_wr_cnt", wr_cnt, 7);
        check("g_rempty", rempty, 1'b1);
        check_writes("g_post_rst_wr");
        pulse_rdone();
        check("g_rempty_drained", rempty, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
